// File: rtl/board_vram_pkg.sv
// board_vram_pkg: board geometry, cell encodings and arbiter states shared by the VRAM write path.
package board_vram_pkg;
   localparam int BOARD_W      = 14;
   localparam int BOARD_H      = 14;
   localparam int BOARD_CELLS  = BOARD_W * BOARD_H;
   localparam int CELL_DATA_W  = 6;
   localparam int BOARD_ADDR_W = 8;
   localparam logic [CELL_DATA_W-1:0] CELL_EMPTY  = 6'd0;
   localparam logic [CELL_DATA_W-1:0] CELL_P1     = 6'd1;
   localparam logic [CELL_DATA_W-1:0] CELL_P2     = 6'd2;
   localparam logic [CELL_DATA_W-1:0] CELL_CURSOR = 6'd3;
   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/board_xy_to_addr.sv
// board_xy_to_addr: maps board (x,y) to a linear VRAM address and flags cells outside the board.
module board_xy_to_addr #(
   parameter int BOARD_W = 14,
   parameter int BOARD_H = 14,
   parameter int ADDR_W  = 8
) (
   input  logic [3:0]        i_x,
   input  logic [3:0]        i_y,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_in_range
);
   logic [ADDR_W-1:0] w_x, w_y;
   assign w_x = ADDR_W'(i_x);
   assign w_y = ADDR_W'(i_y);
   assign o_in_range = (int'(i_x) < BOARD_W) && (int'(i_y) < BOARD_H);
   // 14-wide boards avoid a multiplier: y*14 = 16y - 2y
   generate
      if (BOARD_W == 14) begin : g_shift
         assign o_addr = (w_y << 4) - (w_y << 1) + w_x;
      end else begin : g_mul
         assign o_addr = w_y * ADDR_W'(BOARD_W) + w_x;
      end
   endgenerate
endmodule

// File: rtl/board_vram_write_arbiter.sv
// board_vram_write_arbiter: round-robin owner of the board VRAM write port with full-board clear.
// Optional BOARD_WR_COUNT_EN adds a saturating count of issued requester writes.
module board_vram_write_arbiter
   import board_vram_pkg::*;
#(
   parameter int BOARD_W        = board_vram_pkg::BOARD_W,
   parameter int BOARD_H        = board_vram_pkg::BOARD_H,
   parameter int DATA_W         = board_vram_pkg::CELL_DATA_W,
   parameter int ADDR_W         = board_vram_pkg::BOARD_ADDR_W,
   parameter int CLEAR_VAL      = 0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              req0_valid,
   input  logic [3:0]        req0_x,
   input  logic [3:0]        req0_y,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [3:0]        req1_x,
   input  logic [3:0]        req1_y,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic [ADDR_W-1:0] vram_wraddress,
   output logic [DATA_W-1:0] vram_data,
   output logic              vram_wren,
   output logic              err_oob
`ifdef BOARD_WR_COUNT_EN
   ,output logic [15:0]      wr_count
`endif
);
   state_t            r_state, w_next;
   logic              r_ptr, r_wren, r_err, r_busy;
   logic [ADDR_W-1:0] r_clear_addr, r_addr, w_addr;
   logic [DATA_W-1:0] r_data, w_data;
   logic              w_idle, w_clear, w_last, w_g0, w_g1, w_grant, w_in_range;
   logic [3:0]        w_x, w_y;

   always_comb begin
      w_clear = r_state == ST_CLEAR;
      w_idle  = !w_clear && !clear_req;
      w_last  = r_clear_addr == ADDR_W'(BOARD_W * BOARD_H - 1);
      w_g0    = w_idle && req0_valid && (!req1_valid || !r_ptr);
      w_g1    = w_idle && req1_valid && (!req0_valid || r_ptr);
      w_grant = w_g0 || w_g1;
      w_x     = w_g1 ? req1_x : req0_x;
      w_y     = w_g1 ? req1_y : req0_y;
      w_data  = w_g1 ? req1_data : req0_data;
      w_next  = w_clear ? (w_last ? ST_IDLE : ST_CLEAR) : (clear_req ? ST_CLEAR : ST_IDLE);
   end

   board_xy_to_addr #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_W(ADDR_W)) u_xy (
      .i_x       (w_x),
      .i_y       (w_y),
      .o_addr    (w_addr),
      .o_in_range(w_in_range)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         r_clear_addr <= '0;
         r_ptr        <= 1'b0;
         r_wren       <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_clear_addr <= w_clear ? r_clear_addr + ADDR_W'(1) : '0;
         r_ptr        <= (w_idle && req0_valid && req1_valid) ? !r_ptr : r_ptr;
         r_wren       <= w_clear || (w_grant && w_in_range);
         r_addr       <= w_clear ? r_clear_addr : (w_grant ? w_addr : r_addr);
         r_data       <= w_clear ? DATA_W'(CLEAR_VAL) : (w_grant ? w_data : r_data);
         r_err        <= w_grant && !w_in_range;
         r_busy       <= w_clear;
      end
   end

   assign req0_ready     = w_g0;
   assign req1_ready     = w_g1;
   assign vram_wren      = r_wren;
   assign vram_wraddress = r_addr;
   assign vram_data      = r_data;
   assign err_oob        = r_err;
   assign clear_busy     = r_busy;

`ifdef BOARD_WR_COUNT_EN
   logic [15:0] r_wr_count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wr_count <= '0;
      else
         r_wr_count <= (w_next == ST_CLEAR) ? '0 :
                       (w_grant && w_in_range && r_wr_count != 16'hFFFF) ? r_wr_count + 16'd1 : r_wr_count;
   end
   assign wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_board_vram_write_arbiter.sv
// tb_board_vram_write_arbiter: scoreboard bench for the VRAM write arbiter (reset clear, grants, OOB, clear request, mid-clear reset).
module tb_board_vram_write_arbiter;
   logic       clk = 1'b0;
   logic       rst, clear_req, clear_busy;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_x, req0_y, req1_x, req1_y;
   logic [5:0] req0_data, req1_data, vram_data;
   logic [7:0] vram_wraddress;
   logic       vram_wren, err_oob;
`ifdef BOARD_WR_COUNT_EN
   logic [15:0] wr_count;
`endif

   typedef struct {bit wren; bit [7:0] addr; bit [5:0] data; bit err;} exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   board_vram_write_arbiter dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
      .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data), .req1_ready(req1_ready),
      .vram_wraddress(vram_wraddress), .vram_data(vram_data), .vram_wren(vram_wren), .err_oob(err_oob)
`ifdef BOARD_WR_COUNT_EN
      , .wr_count(wr_count)
`endif
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Walks one full clear: the next negedge must show address 0, the 196th shows address 195.
   task automatic test_clear_walk(input string name);
      for (int i = 0; i < 196; i++) q.push_back('{1'b1, 8'(i), 6'd0, 1'b0});
      for (int i = 0; i < 196; i++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if (vram_wren !== e.wren || err_oob !== e.err || vram_wraddress !== e.addr || vram_data !== e.data) begin
            failures++;
            $display("FAIL %s_write[%0d]: got wren=%b addr=%0d data=%0h err=%b want wren=%b addr=%0d data=%0h err=%b",
                     name, i, vram_wren, vram_wraddress, vram_data, err_oob, e.wren, e.addr, e.data, e.err);
         end
         checks++;
         if (clear_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy[%0d]: got %b want 1", name, i, clear_busy);
         end
         if (i < 195) begin
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
               failures++;
               $display("FAIL %s_ready[%0d]: got %b%b want 00", name, i, req0_ready, req1_ready);
            end
         end
         clear_req = (i == 50);
      end
      clear_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear_req = 1'b0;
      req0_valid = 1'b1; req0_x = 4'd1; req0_y = 4'd1; req0_data = 6'h3F;
      req1_valid = 1'b1; req1_x = 4'd2; req1_y = 4'd2; req1_data = 6'h2A;
      repeat (3) @(negedge clk);
      checks++;
      if (vram_wren !== 1'b0 || vram_wraddress !== 8'd0 || vram_data !== 6'd0 || err_oob !== 1'b0 ||
          clear_busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got wren=%b addr=%0d data=%0h err=%b busy=%b rdy=%b%b want all 0",
                  vram_wren, vram_wraddress, vram_data, err_oob, clear_busy, req0_ready, req1_ready);
      end
`ifdef BOARD_WR_COUNT_EN
      checks++;
      if (wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
`endif
      rst = 1'b0;
      test_clear_walk("reset_clear");
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (clear_busy !== 1'b0 || vram_wren !== 1'b0 || err_oob !== 1'b0) begin
         failures++;
         $display("FAIL reset_clear_done: got busy=%b wren=%b err=%b want 0 0 0", clear_busy, vram_wren, err_oob);
      end
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_x = 4'd3; req0_y = 4'd2; req0_data = 6'h05;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
      end
      q.push_back('{1'b1, 8'd31, 6'h05, 1'b0});
      @(negedge clk);
      req0_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (vram_wren !== e.wren || err_oob !== e.err || vram_wraddress !== e.addr || vram_data !== e.data) begin
         failures++;
         $display("FAIL single_write: got wren=%b addr=%0d data=%0h err=%b want wren=%b addr=%0d data=%0h err=%b",
                  vram_wren, vram_wraddress, vram_data, err_oob, e.wren, e.addr, e.data, e.err);
      end
   endtask

   task automatic test_round_robin();
      int g;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1; req0_x = 4'(i); req0_y = 4'd1; req0_data = 6'(10 + i);
         req1_valid = 1'b1; req1_x = 4'd0; req1_y = 4'(13 - i); req1_data = 6'(40 + i);
         g = i % 2;
         #1;
         checks++;
         if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
            failures++;
            $display("FAIL rr_grant[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, g == 0, g == 1);
         end
         if (g == 0) q.push_back('{1'b1, 8'(1 * 14 + i), 6'(10 + i), 1'b0});
         else        q.push_back('{1'b1, 8'((13 - i) * 14), 6'(40 + i), 1'b0});
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if (vram_wren !== e.wren || err_oob !== e.err || vram_wraddress !== e.addr || vram_data !== e.data) begin
            failures++;
            $display("FAIL rr_write[%0d]: got wren=%b addr=%0d data=%0h err=%b want wren=%b addr=%0d data=%0h err=%b",
                     i, vram_wren, vram_wraddress, vram_data, err_oob, e.wren, e.addr, e.data, e.err);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_oob();
      for (int k = 0; k < 2; k++) begin
         req0_valid = (k == 1); req0_x = 4'd0;  req0_y = 4'd14; req0_data = 6'h11;
         req1_valid = (k == 0); req1_x = 4'd14; req1_y = 4'd0;  req1_data = 6'h03;
         #1;
         checks++;
         if (req0_ready !== (k == 1) || req1_ready !== (k == 0)) begin
            failures++;
            $display("FAIL oob_ready[%0d]: got %b%b want %b%b", k, req0_ready, req1_ready, k == 1, k == 0);
         end
         q.push_back('{1'b0, 8'd0, 6'd0, 1'b1});
         q.push_back('{1'b0, 8'd0, 6'd0, 1'b0});
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (vram_wren !== e.wren || err_oob !== e.err) begin
               failures++;
               $display("FAIL oob_pulse[%0d.%0d]: got wren=%b err=%b want wren=%b err=%b", k, c, vram_wren, err_oob, e.wren, e.err);
            end
         end
      end
`ifdef BOARD_WR_COUNT_EN
      checks++;
      if (wr_count !== 16'd5) begin failures++; $display("FAIL oob_wr_count: got %0d want 5", wr_count); end
`endif
   endtask

   task automatic test_clear_req();
      clear_req = 1'b1;
      req0_valid = 1'b1; req0_x = 4'd5; req0_y = 4'd5; req0_data = 6'h07;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL clrreq_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      @(negedge clk);
      clear_req = 1'b0;
      checks++;
      if (vram_wren !== 1'b0) begin failures++; $display("FAIL clrreq_no_write: got wren=%b want 0", vram_wren); end
`ifdef BOARD_WR_COUNT_EN
      checks++;
      if (wr_count !== 16'd0) begin failures++; $display("FAIL clrreq_wr_count: got %0d want 0", wr_count); end
`endif
      test_clear_walk("clrreq_clear");
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin failures++; $display("FAIL clrreq_first_idle_grant: got %b want 1", req0_ready); end
      q.push_back('{1'b1, 8'd75, 6'h07, 1'b0});
      @(negedge clk);
      req0_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (vram_wren !== e.wren || err_oob !== e.err || vram_wraddress !== e.addr || vram_data !== e.data || clear_busy !== 1'b0) begin
         failures++;
         $display("FAIL clrreq_after_write: got wren=%b addr=%0d data=%0h busy=%b want wren=%b addr=%0d data=%0h busy=0",
                  vram_wren, vram_wraddress, vram_data, clear_busy, e.wren, e.addr, e.data);
      end
`ifdef BOARD_WR_COUNT_EN
      checks++;
      if (wr_count !== 16'd1) begin failures++; $display("FAIL clrreq_after_wr_count: got %0d want 1", wr_count); end
`endif
   endtask

   task automatic test_reset_mid_clear();
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (100) @(negedge clk);
      checks++;
      if (vram_wren !== 1'b1 || vram_wraddress !== 8'd99) begin
         failures++;
         $display("FAIL midclr_progress: got wren=%b addr=%0d want wren=1 addr=99", vram_wren, vram_wraddress);
      end
      req0_valid = 1'b1; req0_x = 4'd1; req0_y = 4'd0; req0_data = 6'h09;
      rst = 1'b1;
      #1;
      checks++;
      if (vram_wren !== 1'b0 || vram_wraddress !== 8'd0 || vram_data !== 6'd0 || err_oob !== 1'b0 ||
          clear_busy !== 1'b0 || req0_ready !== 1'b0) begin
         failures++;
         $display("FAIL midclr_async_reset: got wren=%b addr=%0d data=%0h err=%b busy=%b rdy0=%b want all 0",
                  vram_wren, vram_wraddress, vram_data, err_oob, clear_busy, req0_ready);
      end
`ifdef BOARD_WR_COUNT_EN
      checks++;
      if (wr_count !== 16'd0) begin failures++; $display("FAIL midclr_wr_count: got %0d want 0", wr_count); end
`endif
      @(negedge clk);
      rst = 1'b0;
      test_clear_walk("midclr_restart");
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (clear_busy !== 1'b0 || vram_wren !== 1'b0) begin
         failures++;
         $display("FAIL midclr_done: got busy=%b wren=%b want 0 0", clear_busy, vram_wren);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_oob();
      test_clear_req();
      test_reset_mid_clear();
      checks++;
      if (q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d left want 0", q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
